// File: rtl/gtx_rx.sv
// Receive framer: hunts the periodic comma, fixes a one-byte lane offset, qualifies lock and emits payload.
// Latency 2 clk from data_i to data_o/valid_o; no backpressure, the RX stream is consumed every cycle.
module gtx_rx #(
    parameter logic [15:0] COMMA    = 16'hbcbc,
    parameter int          PERIOD   = 16,
    parameter int          LOCK_CNT = 3,
    parameter int          LOSS_CNT = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [1:0]  ctrl_i,
    input  logic [15:0] data_i,
    output logic [15:0] data_o,
    output logic        valid_o,
    output logic        sync_o,
    output logic        err_o
);

    localparam int SW = $clog2(PERIOD);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(LOSS_CNT + 1);

    typedef struct packed {
        logic [1:0]  ctrl;
        logic [15:0] dat;
    } rx_word_t;

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    rx_word_t        r_cur;
    logic [7:0]      r_prv_hi;
    logic            r_prv_hi_k;
    logic            r_offset;
    state_t          r_state;
    logic [SW-1:0]   r_slot;
    logic [GW-1:0]   r_good;
    logic [MW-1:0]   r_miss;
    logic [15:0]     r_dat;
    logic            r_vld;
    logic            r_err;

    rx_word_t        w_algn;
    logic            w_acomma;
    logic            w_scomma;
    logic            w_rcomma;
    logic            w_slot0;
    logic [SW-1:0]   w_slot_inc;
    state_t          w_state_nxt;
    logic            w_offset_nxt;
    logic [SW-1:0]   w_slot_nxt;
    logic [GW-1:0]   w_good_nxt;
    logic [MW-1:0]   w_miss_nxt;
    logic            w_vld_nxt;
    logic            w_err_nxt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cur      <= '0;
            r_prv_hi   <= '0;
            r_prv_hi_k <= 1'b0;
        end else begin
            r_cur      <= '{ctrl: ctrl_i, dat: data_i};
            r_prv_hi   <= r_cur.dat[15:8];
            r_prv_hi_k <= r_cur.ctrl[1];
        end
    end

    // With offset=1 the word straddles cur and prv: prv's upper byte came first on the wire.
    always_comb begin
        w_algn = r_cur;
        if (r_offset) begin
            w_algn.ctrl = {r_cur.ctrl[0], r_prv_hi_k};
            w_algn.dat  = {r_cur.dat[7:0], r_prv_hi};
        end
    end

    assign w_acomma   = (w_algn.ctrl == 2'b11) && (w_algn.dat == COMMA);
    assign w_scomma   = (r_cur.ctrl == 2'b10) && (r_cur.dat[15:8] == COMMA[15:8]);
    assign w_rcomma   = (r_cur.ctrl == 2'b11) && (r_cur.dat == COMMA);
    assign w_slot0    = (r_slot == '0);
    assign w_slot_inc = (r_slot == SW'(PERIOD - 1)) ? '0 : r_slot + SW'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_offset_nxt = r_offset;
        w_slot_nxt   = w_slot_inc;
        w_good_nxt   = r_good;
        w_miss_nxt   = r_miss;
        w_vld_nxt    = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            HUNT: begin
                w_good_nxt = '0;
                w_miss_nxt = '0;
                if (w_acomma) begin
                    w_state_nxt = CHECK;
                    w_good_nxt  = GW'(1);
                    w_slot_nxt  = SW'(1);
                end else if (!r_offset && w_scomma) begin
                    w_offset_nxt = 1'b1;
                end else if (r_offset && w_rcomma) begin
                    // A stale offset would otherwise hide an aligned stream forever.
                    w_offset_nxt = 1'b0;
                end
            end
            CHECK: begin
                if (w_slot0) begin
                    if (w_acomma) begin
                        if (r_good == GW'(LOCK_CNT - 1)) begin
                            w_state_nxt = LOCKED;
                            w_miss_nxt  = '0;
                        end
                        w_good_nxt = r_good + GW'(1);
                    end else begin
                        w_state_nxt = HUNT;
                        w_good_nxt  = '0;
                    end
                end else if (w_acomma) begin
                    w_slot_nxt = SW'(1);
                    w_good_nxt = GW'(1);
                end else if (w_algn.ctrl != 2'b00) begin
                    w_err_nxt = 1'b1;
                end
            end
            LOCKED: begin
                if (w_slot0) begin
                    if (w_acomma) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_err_nxt = 1'b1;
                        if (r_miss == MW'(LOSS_CNT - 1)) begin
                            w_state_nxt = HUNT;
                            w_miss_nxt  = '0;
                            w_good_nxt  = '0;
                        end else begin
                            w_miss_nxt = r_miss + MW'(1);
                        end
                    end
                end else if (w_algn.ctrl != 2'b00) begin
                    w_err_nxt = 1'b1;
                end else begin
                    w_vld_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= HUNT;
            r_offset <= 1'b0;
            r_slot   <= '0;
            r_good   <= '0;
            r_miss   <= '0;
            r_dat    <= '0;
            r_vld    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_offset <= w_offset_nxt;
            r_slot   <= w_slot_nxt;
            r_good   <= w_good_nxt;
            r_miss   <= w_miss_nxt;
            r_vld    <= w_vld_nxt;
            r_err    <= w_err_nxt;
            if (w_vld_nxt) begin
                r_dat <= w_algn.dat;
            end
        end
    end

    assign data_o  = r_dat;
    assign valid_o = r_vld;
    assign err_o   = r_err;
    assign sync_o  = (r_state == LOCKED);

endmodule

// File: tb/tb_gtx_rx.sv
// Directed bench for gtx_rx: every driven word queues its expected output, compared when it emerges.
// Shifted-lane words carry the expectation of the word they complete.
module tb_gtx_rx;

    typedef struct packed {
        logic        vld;
        logic        err;
        logic        sync;
        logic [15:0] dat;
    } exp_t;

    logic        clk;
    logic        rst_n_i;
    logic [1:0]  ctrl_i;
    logic [15:0] data_i;
    logic [15:0] data_o;
    logic        valid_o;
    logic        sync_o;
    logic        err_o;

    int          checks;
    int          errors;
    int          stepn;
    string       phase;
    exp_t        sb[$];
    logic        shift;
    logic [1:0]  p_ctrl;
    logic [15:0] p_dat;
    exp_t        p_exp;
    logic [15:0] hold_dat;

    gtx_rx dut (
        .clk_i   (clk),
        .rst_n_i (rst_n_i),
        .ctrl_i  (ctrl_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .sync_o  (sync_o),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s step %0d observed=%h expected=%h", phase, tag, stepn, obs, exp);
        end
    endtask

    // Drive one true word (aligned or lane-shifted), then compare the oldest pending output.
    task automatic send(input logic [1:0] c, input logic [15:0] d,
                        input logic ev, input logic ee, input logic es);
        exp_t e;
        exp_t x;
        e.vld  = ev;
        e.err  = ee;
        e.sync = es;
        e.dat  = d;
        if (!shift) begin
            ctrl_i = c;
            data_i = d;
            sb.push_back(e);
        end else begin
            ctrl_i = {c[0], p_ctrl[1]};
            data_i = {d[7:0], p_dat[15:8]};
            sb.push_back(p_exp);
        end
        p_ctrl = c;
        p_dat  = d;
        p_exp  = e;
        stepn++;
        @(posedge clk);
        #1;
        if (sb.size() > 1) begin
            x = sb.pop_front();
            if (x.vld) hold_dat = x.dat;
            chk("valid", {15'b0, valid_o}, {15'b0, x.vld});
            chk("err",   {15'b0, err_o},   {15'b0, x.err});
            chk("sync",  {15'b0, sync_o},  {15'b0, x.sync});
            chk("data",  data_o, hold_dat);
        end
    endtask

    task automatic pay(input int lo, input int hi, input logic pv, input logic ps);
        for (int i = lo; i <= hi; i++) send(2'b00, 16'(i), pv, 1'b0, ps);
    endtask

    task automatic frame(input logic cs, input logic pv, input logic ps);
        send(2'b11, 16'hbcbc, 1'b0, 1'b0, cs);
        pay(1, 15, pv, ps);
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        #2;
        chk("rst_data",  data_o, 16'h0000);
        chk("rst_valid", {15'b0, valid_o}, 16'h0000);
        chk("rst_sync",  {15'b0, sync_o},  16'h0000);
        chk("rst_err",   {15'b0, err_o},   16'h0000);
        sb.delete();
        ctrl_i = 2'b00;
        data_i = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        rst_n_i  = 1'b1;
        p_ctrl   = 2'b00;
        p_dat    = 16'h0000;
        p_exp    = '0;
        hold_dat = 16'h0000;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        stepn    = 0;
        shift    = 1'b0;
        rst_n_i  = 1'b1;
        ctrl_i   = 2'b00;
        data_i   = 16'h0000;
        p_ctrl   = 2'b00;
        p_dat    = 16'h0000;
        p_exp    = '0;
        hold_dat = 16'h0000;
        #3;

        phase = "reset";
        do_reset();

        phase = "aligned_lock";
        repeat (3) send(2'b00, 16'h0000, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b1, 1'b1, 1'b1);
        frame(1'b1, 1'b1, 1'b1);

        phase = "miss_one";
        send(2'b00, 16'h1234, 1'b0, 1'b1, 1'b1);
        pay(1, 15, 1'b1, 1'b1);
        frame(1'b1, 1'b1, 1'b1);
        phase = "miss_two";
        send(2'b00, 16'h1234, 1'b0, 1'b1, 1'b1);
        pay(1, 15, 1'b1, 1'b1);
        send(2'b00, 16'h1234, 1'b0, 1'b1, 1'b0);
        pay(1, 15, 1'b0, 1'b0);
        phase = "relock";
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b1, 1'b1, 1'b1);

        phase = "stray_comma";
        send(2'b11, 16'hbcbc, 1'b0, 1'b0, 1'b1);
        pay(1, 6, 1'b1, 1'b1);
        send(2'b11, 16'hbcbc, 1'b0, 1'b1, 1'b1);
        pay(8, 9, 1'b1, 1'b1);
        send(2'b01, 16'h001c, 1'b0, 1'b1, 1'b1);
        pay(11, 15, 1'b1, 1'b1);
        frame(1'b1, 1'b1, 1'b1);

        phase = "reset_locked";
        send(2'b11, 16'hbcbc, 1'b0, 1'b0, 1'b1);
        pay(1, 5, 1'b1, 1'b1);
        do_reset();

        phase = "shifted_lock";
        shift = 1'b1;
        repeat (3) send(2'b00, 16'h0000, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b1, 1'b1, 1'b1);
        frame(1'b1, 1'b1, 1'b1);
        send(2'b11, 16'hbcbc, 1'b0, 1'b0, 1'b1);
        send(2'b00, 16'h0001, 1'b1, 1'b0, 1'b1);

        phase = "reset_shifted";
        do_reset();
        shift = 1'b0;

        phase = "check_rebase";
        repeat (2) send(2'b00, 16'h0000, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        send(2'b11, 16'hbcbc, 1'b0, 1'b0, 1'b0);
        pay(1, 2, 1'b0, 1'b0);
        send(2'b01, 16'h00f7, 1'b0, 1'b1, 1'b0);
        pay(4, 4, 1'b0, 1'b0);
        send(2'b11, 16'hbcbc, 1'b0, 1'b0, 1'b0);
        pay(1, 15, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b1, 1'b1, 1'b1);
        send(2'b11, 16'hbcbc, 1'b0, 1'b0, 1'b1);
        send(2'b00, 16'h0001, 1'b1, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
